bls_operand_dispatcher: RTL and testbench
=========================================

# bls_operand_dispatcher

Upstream data stage for the Black-Scholes controller. Accepts a stream of 192-bit option records and loads them, one per cycle, into per-module operand registers when the controller requests them via its serve lines. Produces the per-module `has_unused`, `reg_ready` and global `out_of_data` status the controller consumes. Retires a slot's data when the controller starts that module.

## Interface
- `NUM_MODS`, 20, number of Black-Scholes modules / operand slots
- `DATA_W`, 192, record width in bits
- `CNT_W`, 16, width of the record-count and remaining-count registers

Ports:
- `clock` in 1: clock
- `reset` in 1: reset, asynchronous, active-high
- `start` in 1: arm a round; sampled in IDLE or EXHAUSTED only
- `num_records` in CNT_W: records in this round, sampled with `start`
- `rec_valid` in 1: upstream record valid
- `rec_ready` out 1: dispatcher accepts `rec_data` this cycle
- `rec_data` in DATA_W: record payload
- `serve_req` in NUM_MODS: per-slot fetch request from controller
- `bs_start` in NUM_MODS: per-slot consume strobe from controller
- `operand_data` out NUM_MODS*DATA_W: slot i at bits [i*DATA_W +: DATA_W]
- `has_unused` out NUM_MODS: slot holds unconsumed record
- `reg_ready` out NUM_MODS: slot data settled, usable by module
- `out_of_data` out 1: no records left to fetch this round
- `issued` out CNT_W: records accepted this round
- `stall_cycles` out 32: see Configuration

## Operation
- FSM states:
  - IDLE → ACTIVE on `start`. Loads remaining = `num_records` and clears `issued`.
  - If `num_records`==0, IDLE → EXHAUSTED directly on `start`.
  - ACTIVE → EXHAUSTED on the cycle remaining reaches 0.
  - EXHAUSTED → ACTIVE (or EXHAUSTED if 0) on `start`.
  - `start` in ACTIVE is ignored.
- Eligible slot i: `serve_req[i]` && !`has_unused[i]`.
- Grant:
  - Round-robin among eligible slots, starting from pointer `rr`.
  - At most one grant per cycle.
  - `rr` ← granted index+1, wrapping from NUM_MODS-1 to 0; `rr` is unchanged when there is no handshake.
- `rec_ready` = state==ACTIVE && any eligible slot && remaining!=0.
- On handshake (`rec_valid`&&`rec_ready`):
  - Write `rec_data` to the granted slot.
  - Set `has_unused[g]`.
  - Decrement remaining; increment `issued`.
- `reg_ready[i]` is set one cycle after `has_unused[i]` rises (settle stage).
- `bs_start[i]` clears both `has_unused[i]` and `reg_ready[i]` next cycle.
  - Ignored when `has_unused[i]`==0.
  - Operand contents are retained after clearing.
- Simultaneous load and consume on one slot is impossible, because grant requires `has_unused[i]`==0.
- `serve_req` on a loaded slot is ignored.
- `out_of_data` = state!=ACTIVE. It is 1 in IDLE, 0 while ACTIVE, and 1 in EXHAUSTED.
- Reset mid-round:
  - All slots cleared; FSM to IDLE; in-flight record dropped.
  - Upstream must restart the stream.

## Timing
- Reset values:
  - `rec_ready`=0, `has_unused`=0, `reg_ready`=0, `operand_data`=0.
  - `out_of_data`=1, `issued`=0, `stall_cycles`=0, `rr`=0, state IDLE.
- `rec_ready` is combinational from `serve_req` plus registered state. Upstream must not combinationally depend on `rec_ready` to drive `rec_valid`.
- Latency:
  - Handshake in cycle N → `has_unused` high in N+1 → `reg_ready` high in N+2.
  - `bs_start` in cycle M → both low in M+1.
- Peak throughput is one record per cycle.
- The last handshake (remaining 1→0) makes `out_of_data` high the next cycle.
- remaining and `issued` never wrap. `issued` saturates at `num_records`.

## Configuration
- `BLS_DISPATCH_STATS_EN` defined:
  - `stall_cycles` counts ACTIVE cycles with any eligible slot && remaining!=0 && !`rec_valid`.
  - Saturates at 2^32-1; cleared on `start`.
- Undefined: `stall_cycles` tied to 0 and no counter logic is built.

## Test plan
- Reset, then `start` with `num_records`=3, `serve_req`=all ones, `rec_valid`=1 → slots 0,1,2 loaded on consecutive cycles; `out_of_data`=1 three cycles after first handshake; `issued`=3.
- `serve_req`=bits {5,12} for 4 cycles with `has_unused` of both cleared by `bs_start` after each load → grants alternate 5,12,5,12 (round-robin fairness).
- Handshake to slot 7 at cycle N → `has_unused[7]`=1 at N+1, `reg_ready[7]`=1 at N+2; `bs_start[7]` at N+3 → both 0 at N+4; `bs_start[7]` again at N+5 → no change.
- `start` with `num_records`=0 → `out_of_data` stays 1, `rec_ready` never asserts.
- Reset asserted mid-round with 4 slots loaded → all outputs return to reset values immediately; a new `start` with `num_records`=2 loads normally.
- With `BLS_DISPATCH_STATS_EN`: ACTIVE, `serve_req[0]`=1, `rec_valid`=0 for 10 cycles → `stall_cycles`=10. Without the macro → 0.

Source files
------------

// File: rtl/bls_operand_dispatcher.sv
// Operand dispatcher for the Black-Scholes controller: loads streamed records into per-module slots.
// Optional stall statistics counter is built when BLS_DISPATCH_STATS_EN is defined.
module bls_operand_dispatcher #(
   parameter int NUM_MODS = 20,
   parameter int DATA_W   = 192,
   parameter int CNT_W    = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [CNT_W-1:0]             num_records,
   input  logic                         rec_valid,
   output logic                         rec_ready,
   input  logic [DATA_W-1:0]            rec_data,
   input  logic [NUM_MODS-1:0]          serve_req,
   input  logic [NUM_MODS-1:0]          bs_start,
   output logic [NUM_MODS*DATA_W-1:0]   operand_data,
   output logic [NUM_MODS-1:0]          has_unused,
   output logic [NUM_MODS-1:0]          reg_ready,
   output logic                         out_of_data,
   output logic [CNT_W-1:0]             issued,
   output logic [31:0]                  stall_cycles
);

   localparam int IDX_W = $clog2(NUM_MODS);
   localparam logic [IDX_W:0] NUM_MODS_W = (IDX_W+1)'(NUM_MODS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MODS - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_EXH    = 2'd2;

   logic [1:0]                 state_q, state_d;
   logic [CNT_W-1:0]           remaining_q, remaining_d;
   logic [CNT_W-1:0]           issued_q, issued_d;
   logic [IDX_W-1:0]           rr_q, rr_d;
   logic [NUM_MODS-1:0]        has_unused_q, has_unused_d;
   logic [NUM_MODS-1:0]        reg_ready_q, reg_ready_d;
   logic [NUM_MODS*DATA_W-1:0] operand_q, operand_d;

   logic [NUM_MODS-1:0]        eligible_s;
   logic [NUM_MODS-1:0]        grant_oh_s;
   logic [NUM_MODS-1:0]        clear_s;
   logic [IDX_W-1:0]           grant_idx_s;
   logic [IDX_W:0]             idx_v;
   logic                       grant_any_s;
   logic                       rec_ready_s;
   logic                       hs_s;

   assign eligible_s  = serve_req & ~has_unused_q;
   assign rec_ready_s = (state_q == ST_ACTIVE) && (|eligible_s) && (remaining_q != '0);
   assign hs_s        = rec_valid && rec_ready_s;
   // A consume strobe only retires a slot that actually holds data.
   assign clear_s     = bs_start & has_unused_q;

   // Round-robin search for the first eligible slot at or after rr.
   always_comb begin
      grant_any_s = 1'b0;
      grant_idx_s = '0;
      grant_oh_s  = '0;
      idx_v       = '0;
      for (int k = 0; k < NUM_MODS; k++) begin
         idx_v = {1'b0, rr_q} + (IDX_W+1)'(k);
         idx_v = (idx_v >= NUM_MODS_W) ? (idx_v - NUM_MODS_W) : idx_v;
         if (!grant_any_s && eligible_s[idx_v[IDX_W-1:0]]) begin
            grant_any_s = 1'b1;
            grant_idx_s = idx_v[IDX_W-1:0];
         end else begin
            grant_any_s = grant_any_s;
         end
      end
      if (grant_any_s) begin
         grant_oh_s[grant_idx_s] = 1'b1;
      end else begin
         grant_oh_s = '0;
      end
   end

   // Round FSM, remaining/issued counters and round-robin pointer.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      issued_d    = issued_q;
      rr_d        = rr_q;
      case (state_q)
         ST_IDLE, ST_EXH: begin
            if (start) begin
               remaining_d = num_records;
               issued_d    = '0;
               state_d     = (num_records == '0) ? ST_EXH : ST_ACTIVE;
            end else begin
               state_d = state_q;
            end
         end
         ST_ACTIVE: begin
            if (hs_s) begin
               remaining_d = remaining_q - CNT_W'(1);
               issued_d    = issued_q + CNT_W'(1);
               state_d     = (remaining_q == CNT_W'(1)) ? ST_EXH : ST_ACTIVE;
               rr_d        = (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + IDX_W'(1);
            end else if (remaining_q == '0) begin
               state_d = ST_EXH;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Slot status and operand storage; reg_ready trails has_unused by one settle cycle.
   always_comb begin
      has_unused_d = has_unused_q & ~clear_s;
      reg_ready_d  = has_unused_q & ~clear_s;
      operand_d    = operand_q;
      if (hs_s) begin
         has_unused_d = has_unused_d | grant_oh_s;
      end else begin
         has_unused_d = has_unused_d;
      end
      for (int i = 0; i < NUM_MODS; i++) begin
         if (hs_s && grant_oh_s[i]) begin
            operand_d[i*DATA_W +: DATA_W] = rec_data;
         end else begin
            operand_d[i*DATA_W +: DATA_W] = operand_q[i*DATA_W +: DATA_W];
         end
      end
   end

   // State registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         remaining_q  <= '0;
         issued_q     <= '0;
         rr_q         <= '0;
         has_unused_q <= '0;
         reg_ready_q  <= '0;
         operand_q    <= '0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         issued_q     <= issued_d;
         rr_q         <= rr_d;
         has_unused_q <= has_unused_d;
         reg_ready_q  <= reg_ready_d;
         operand_q    <= operand_d;
      end
   end

`ifdef BLS_DISPATCH_STATS_EN
   logic [31:0] stall_q, stall_d;

   // Counts cycles where a slot wanted data but upstream had none; saturating.
   always_comb begin
      if (start && (state_q != ST_ACTIVE)) begin
         stall_d = 32'd0;
      end else if (rec_ready_s && !rec_valid && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end else begin
         stall_d = stall_q;
      end
   end

   // Stall counter register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_q <= 32'd0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'd0;
`endif

   assign rec_ready    = rec_ready_s;
   assign operand_data = operand_q;
   assign has_unused   = has_unused_q;
   assign reg_ready    = reg_ready_q;
   assign out_of_data  = (state_q != ST_ACTIVE);
   assign issued       = issued_q;

endmodule

// File: tb/tb_bls_operand_dispatcher.sv
// Directed bench for bls_operand_dispatcher: per-cycle vector table plus hand-written corner sequences.
// Honours BLS_DISPATCH_STATS_EN for the expected stall count.
module tb_bls_operand_dispatcher;

   localparam int NM = 20;
   localparam int DW = 192;
   localparam int CW = 16;

   logic              clock;
   logic              reset;
   logic              start;
   logic [CW-1:0]     num_records;
   logic              rec_valid;
   logic              rec_ready;
   logic [DW-1:0]     rec_data;
   logic [NM-1:0]     serve_req;
   logic [NM-1:0]     bs_start;
   logic [NM*DW-1:0]  operand_data;
   logic [NM-1:0]     has_unused;
   logic [NM-1:0]     reg_ready;
   logic              out_of_data;
   logic [CW-1:0]     issued;
   logic [31:0]       stall_cycles;

   int n_cmp;
   int n_fail;

   bls_operand_dispatcher dut (
      .clock(clock), .reset(reset), .start(start), .num_records(num_records),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
      .serve_req(serve_req), .bs_start(bs_start), .operand_data(operand_data),
      .has_unused(has_unused), .reg_ready(reg_ready), .out_of_data(out_of_data),
      .issued(issued), .stall_cycles(stall_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic          start;
      logic [CW-1:0] num;
      logic          valid;
      logic [NM-1:0] serve;
      logic [NM-1:0] bs;
      logic          e_ready;
      logic [NM-1:0] e_hu;
      logic [NM-1:0] e_rdy;
      logic          e_ood;
      logic [CW-1:0] e_iss;
   } vec_t;

   vec_t tbl[16];

   function automatic logic [DW-1:0] mkd(input int r);
      mkd = {32'(r), 128'hFEED_FACE_0123_4567_89AB_CDEF_0F1E_2D3C, 32'(r) ^ 32'h5A5A_5A5A};
   endfunction

   function automatic vec_t mk(input logic st, input logic [CW-1:0] num, input logic v,
                               input logic [NM-1:0] sv, input logic [NM-1:0] bs,
                               input logic er, input logic [NM-1:0] ehu, input logic [NM-1:0] erdy,
                               input logic eood, input logic [CW-1:0] eiss);
      mk = '{st, num, v, sv, bs, er, ehu, erdy, eood, eiss};
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic drive(input logic st, input logic [CW-1:0] num, input logic v,
                        input logic [DW-1:0] d, input logic [NM-1:0] sv, input logic [NM-1:0] bs);
      start = st; num_records = num; rec_valid = v; rec_data = d; serve_req = sv; bs_start = bs;
   endtask

   localparam logic [NM-1:0] ALL = 20'hF_FFFF;
   localparam logic [NM-1:0] B5  = 20'h0_0020;
   localparam logic [NM-1:0] B12 = 20'h0_1000;
   localparam logic [NM-1:0] B7  = 20'h0_0080;
   localparam logic [NM-1:0] Z   = 20'h0_0000;

   initial begin
      n_cmp = 0;
      n_fail = 0;
      reset = 1'b1;
      drive(1'b0, 16'd0, 1'b0, '0, Z, Z);

      // Reset state
      #1;
      check("rst_rec_ready", 192'(rec_ready), 192'(1'b0));
      check("rst_has_unused", 192'(has_unused), 192'(Z));
      check("rst_reg_ready", 192'(reg_ready), 192'(Z));
      check("rst_out_of_data", 192'(out_of_data), 192'(1'b1));
      check("rst_issued", 192'(issued), 192'(16'd0));
      check("rst_stall", 192'(stall_cycles), 192'(32'd0));
      check("rst_operand_s0", operand_data[0 +: DW], '0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      //        start num     v     serve    bs   rdy   hu            regrdy        ood   iss
      tbl[0]  = mk(1'b1, 16'd3, 1'b1, ALL, Z,    1'b0, Z,            Z,            1'b1, 16'd0);
      tbl[1]  = mk(1'b0, 16'd0, 1'b1, ALL, Z,    1'b1, Z,            Z,            1'b0, 16'd0);
      tbl[2]  = mk(1'b0, 16'd0, 1'b1, ALL, Z,    1'b1, 20'h1,        Z,            1'b0, 16'd1);
      tbl[3]  = mk(1'b0, 16'd0, 1'b1, ALL, Z,    1'b1, 20'h3,        20'h1,        1'b0, 16'd2);
      tbl[4]  = mk(1'b0, 16'd0, 1'b1, ALL, Z,    1'b0, 20'h7,        20'h3,        1'b1, 16'd3);
      tbl[5]  = mk(1'b0, 16'd0, 1'b0, Z,   20'h7,1'b0, 20'h7,        20'h7,        1'b1, 16'd3);
      tbl[6]  = mk(1'b1, 16'd4, 1'b0, Z,   Z,    1'b0, Z,            Z,            1'b1, 16'd3);
      tbl[7]  = mk(1'b0, 16'd0, 1'b1, B5|B12, Z,   1'b1, Z,            Z,            1'b0, 16'd0);
      tbl[8]  = mk(1'b0, 16'd0, 1'b1, B5|B12, B5,  1'b1, B5,           Z,            1'b0, 16'd1);
      tbl[9]  = mk(1'b0, 16'd0, 1'b1, B5|B12, B12, 1'b1, B12,          Z,            1'b0, 16'd2);
      tbl[10] = mk(1'b0, 16'd0, 1'b1, B5|B12, B5,  1'b1, B5,           Z,            1'b0, 16'd3);
      tbl[11] = mk(1'b0, 16'd0, 1'b0, Z,   B12,  1'b0, B12,          Z,            1'b1, 16'd4);
      tbl[12] = mk(1'b0, 16'd0, 1'b0, Z,   Z,    1'b0, Z,            Z,            1'b1, 16'd4);
      tbl[13] = mk(1'b1, 16'd0, 1'b1, ALL, Z,    1'b0, Z,            Z,            1'b1, 16'd4);
      tbl[14] = mk(1'b0, 16'd0, 1'b1, ALL, Z,    1'b0, Z,            Z,            1'b1, 16'd0);
      tbl[15] = mk(1'b0, 16'd0, 1'b1, ALL, Z,    1'b0, Z,            Z,            1'b1, 16'd0);

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].start, tbl[i].num, tbl[i].valid, mkd(i), tbl[i].serve, tbl[i].bs);
         #1;
         check($sformatf("v%0d_rec_ready", i), 192'(rec_ready), 192'(tbl[i].e_ready));
         check($sformatf("v%0d_has_unused", i), 192'(has_unused), 192'(tbl[i].e_hu));
         check($sformatf("v%0d_reg_ready", i), 192'(reg_ready), 192'(tbl[i].e_rdy));
         check($sformatf("v%0d_out_of_data", i), 192'(out_of_data), 192'(tbl[i].e_ood));
         check($sformatf("v%0d_issued", i), 192'(issued), 192'(tbl[i].e_iss));
         step();
      end
      check("slot0_data", operand_data[0*DW +: DW], mkd(1));
      check("slot1_data", operand_data[1*DW +: DW], mkd(2));
      check("slot2_data", operand_data[2*DW +: DW], mkd(3));
      check("slot5_data", operand_data[5*DW +: DW], mkd(9));
      check("slot12_data", operand_data[12*DW +: DW], mkd(10));

      // Slot 7 latency and consume behaviour
      drive(1'b1, 16'd5, 1'b0, '0, Z, Z);
      step();
      drive(1'b0, 16'd0, 1'b1, mkd(77), B7, Z);
      #1;
      check("s7_rec_ready_N", 192'(rec_ready), 192'(1'b1));
      step();
      drive(1'b0, 16'd0, 1'b0, '0, Z, Z);
      #1;
      check("s7_hu_N1", 192'(has_unused[7]), 192'(1'b1));
      check("s7_rdy_N1", 192'(reg_ready[7]), 192'(1'b0));
      step();
      check("s7_rdy_N2", 192'(reg_ready[7]), 192'(1'b1));
      step();
      drive(1'b0, 16'd0, 1'b0, '0, Z, B7);
      step();
      drive(1'b0, 16'd0, 1'b0, '0, Z, Z);
      #1;
      check("s7_hu_N4", 192'(has_unused[7]), 192'(1'b0));
      check("s7_rdy_N4", 192'(reg_ready[7]), 192'(1'b0));
      check("s7_data_kept", operand_data[7*DW +: DW], mkd(77));
      step();
      drive(1'b0, 16'd0, 1'b0, '0, Z, B7);
      step();
      drive(1'b0, 16'd0, 1'b0, '0, Z, Z);
      #1;
      check("s7_hu_N6", 192'(has_unused), 192'(Z));
      check("s7_rdy_N6", 192'(reg_ready), 192'(Z));

      // Three more loads continue round-robin from slot 8, leaving one record outstanding
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 16'd0, 1'b1, mkd(80 + i), ALL, Z);
         step();
      end
      drive(1'b0, 16'd0, 1'b0, '0, Z, Z);
      #1;
      check("mid_has_unused", 192'(has_unused), 192'(20'h0_0700));
      check("mid_out_of_data", 192'(out_of_data), 192'(1'b0));
      check("mid_issued", 192'(issued), 192'(16'd4));
      check("slot9_data", operand_data[9*DW +: DW], mkd(81));

      // Mid-round reset clears everything immediately
      reset = 1'b1;
      #1;
      check("mrst_has_unused", 192'(has_unused), 192'(Z));
      check("mrst_reg_ready", 192'(reg_ready), 192'(Z));
      check("mrst_out_of_data", 192'(out_of_data), 192'(1'b1));
      check("mrst_issued", 192'(issued), 192'(16'd0));
      check("mrst_slot8", operand_data[8*DW +: DW], '0);
      @(negedge clock);
      reset = 1'b0;
      drive(1'b1, 16'd2, 1'b1, mkd(90), ALL, Z);
      step();
      drive(1'b0, 16'd0, 1'b1, mkd(91), ALL, Z);
      step();
      drive(1'b0, 16'd0, 1'b1, mkd(92), ALL, Z);
      step();
      drive(1'b0, 16'd0, 1'b0, '0, Z, Z);
      #1;
      check("r2_has_unused", 192'(has_unused), 192'(20'h0_0003));
      check("r2_out_of_data", 192'(out_of_data), 192'(1'b1));
      check("r2_issued", 192'(issued), 192'(16'd2));
      check("r2_slot0", operand_data[0*DW +: DW], mkd(91));
      check("r2_slot1", operand_data[1*DW +: DW], mkd(92));

      // Stall counting: eligible slot, records left, upstream idle for 10 cycles
      drive(1'b1, 16'd3, 1'b0, '0, Z, ALL);
      step();
      drive(1'b0, 16'd0, 1'b0, '0, 20'h0_0001, Z);
      #1;
      check("st_rec_ready", 192'(rec_ready), 192'(1'b1));
      check("st_cleared", 192'(stall_cycles), 192'(32'd0));
      for (int i = 0; i < 10; i++) step();
      #1;
`ifdef BLS_DISPATCH_STATS_EN
      check("st_stall_cycles", 192'(stall_cycles), 192'(32'd10));
`else
      check("st_stall_cycles", 192'(stall_cycles), 192'(32'd0));
`endif
      check("st_issued", 192'(issued), 192'(16'd0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
